mc_fifo_mem: RTL
================

Name: mc_fifo_mem

Overview:
- Parametrised multi-channel FIFO buffer, successor to the single-FIFO memory interface.
- NCH independent FIFOs share one internal dual-port memory array, addressed as {channel, pointer}.
- Each channel has its own pointers, status flags, fill level and sticky error flags.
- Sits between the MAC datapath (writer) and DMA/host logic (reader); one write and one read per clock, to any channels.

Parameters:
- DWIDTH, 32, data word width.
- AWIDTH, 4, per-channel pointer width; depth per channel = 2**AWIDTH.
- NCH, 4, number of channels (>=1); CHW = max(1, clog2(NCH)) is a derived localparam.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  write request.
- wr_ch  input  CHW  target channel for write.
- wr_data  input  DWIDTH  write data.
- rd_en  input  1  read request.
- rd_ch  input  CHW  source channel for read.
- rd_valid  output  1  rd_data valid (one cycle after an accepted read).
- rd_data  output  DWIDTH  read data.
- flush  input  NCH  per-channel synchronous clear.
- full  output  NCH  channel holds 2**AWIDTH words.
- empty  output  NCH  channel holds 0 words.
- level  output  NCH*(AWIDTH+1)  per-channel fill count; channel i occupies bits [i*(AWIDTH+1) +: AWIDTH+1].
- ovf  output  NCH  sticky: a write was attempted while the channel was full.
- udf  output  NCH  sticky: a read was attempted while the channel was empty.

Behaviour:
- Reset (rst=0, asynchronous):
  - All pointers, level, rd_valid, rd_data, ovf and udf go to 0.
  - empty = all ones; full = 0.
  - Memory array contents are not reset.
- Pointers: per channel, wptr and rptr are AWIDTH+1 bits; the MSB is the wrap bit.
  - Memory index = {ch, ptr[AWIDTH-1:0]}.
  - empty when wptr == rptr.
  - full when the low bits are equal and the MSBs differ.
  - level = wptr - rptr, modulo 2**(AWIDTH+1).
  - full, empty and level are registered state and valid in the same cycle as the pointer update.
- Write:
  - Accepted when wr_en=1, wr_ch < NCH, and full[wr_ch]=0 at the clock edge.
  - Memory written at {wr_ch, wptr} and wptr incremented.
  - If full[wr_ch]=1: data is dropped, pointers are unchanged, and ovf[wr_ch] is set.
- Read:
  - Accepted when rd_en=1, rd_ch < NCH, and empty[rd_ch]=0.
  - rd_data is registered from {rd_ch, rptr} and rd_valid=1 on the next cycle; rptr incremented. Latency is exactly 1.
  - If empty[rd_ch]=1: no pointer change, rd_valid=0 next cycle, and udf[rd_ch] is set.
  - rd_data holds its last value when rd_valid=0.
- Out-of-range channel (wr_ch or rd_ch >= NCH): the request is ignored entirely; no flags change.
- Simultaneous write and read, same channel:
  - Both are judged on the pre-edge flags.
  - Full channel: the read is accepted and the write is rejected (ovf set); level = DEPTH-1.
  - Empty channel: the write is accepted and the read is rejected (udf set); no write-to-read bypass.
  - Otherwise both proceed and level is unchanged.
- Simultaneous write and read, different channels: fully independent.
- Flush[i] (synchronous, takes priority):
  - wptr[i] and rptr[i] go to 0; ovf[i] and udf[i] are cleared.
  - Any write or read to channel i in the same cycle is ignored, with no flag set and rd_valid=0 next cycle.
  - Other channels are unaffected.
- Reset during an operation: an in-flight read result is discarded (rd_valid forced to 0).
- Memory: synchronous write; registered read.
  - Read and write to the same address in one cycle cannot occur, because a read requires non-empty and a write targets the wptr slot.

Test Plan:
- Reset, then idle: empty=4'b1111, full=0, every level=0, rd_valid=0, ovf=udf=0.
- Write 0xA0..0xAF to ch2 (16 words): full[2]=1, level ch2=16. A 17th write sets ovf[2] and leaves level at 16. Reading 16 words returns 0xA0..0xAF in order, each with rd_valid one cycle after rd_en; then empty[2]=1.
- Interleave writes to ch0 (0x1xx) and ch3 (0x3xx), then read alternately: each channel returns its own data in order, with no cross-channel corruption; pointer wrap is exercised by 40 writes/reads on ch0 with the level never above 16.
- ch1 full: simultaneous wr_en/rd_en on ch1 gives the read accepted, the write rejected, ovf[1]=1, level=15. ch1 empty: simultaneous write and read gives the write accepted, udf[1]=1, rd_valid=0, level=1.
- ch0 holding 5 words with ovf[0] set: assert flush[0] together with wr_en on ch0. Result: level=0, empty[0]=1, ovf[0]=0, the write is not stored, and the other channels keep their levels.
- Assert rst low mid-burst (rd_en active on ch2 with data pending): rd_valid drops to 0 immediately, and all levels and flags return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/mc_fifo_mem.sv
// Multi-channel FIFO: NCH independent queues sharing one memory array addressed as {channel, pointer}.
// One write and one registered read per clock; per-channel level, full/empty and sticky ovf/udf flags.
module mc_fifo_mem #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4,
    parameter int NCH    = 4,
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [CHW-1:0]           wr_ch,
    input  logic [DWIDTH-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [CHW-1:0]           rd_ch,
    output logic                     rd_valid,
    output logic [DWIDTH-1:0]        rd_data,
    input  logic [NCH-1:0]           flush,
    output logic [NCH-1:0]           full,
    output logic [NCH-1:0]           empty,
    output logic [NCH*(AWIDTH+1)-1:0] level,
    output logic [NCH-1:0]           ovf,
    output logic [NCH-1:0]           udf
);

    localparam int DEPTH = 2 ** AWIDTH;
    localparam int PW    = AWIDTH + 1;
    localparam int MW    = CHW + AWIDTH;

    logic [DWIDTH-1:0]        r_mem [NCH*DEPTH];

    logic [NCH-1:0][PW-1:0]   r_wptr, r_rptr, r_level;
    logic [NCH-1:0]           r_full, r_empty, r_ovf, r_udf;
    logic                     r_rd_valid;
    logic [DWIDTH-1:0]        r_rd_data;

    logic [NCH-1:0][PW-1:0]   w_wptr_nxt, w_rptr_nxt, w_level_nxt;
    logic [NCH-1:0]           w_full_nxt, w_empty_nxt, w_ovf_nxt, w_udf_nxt;
    logic [NCH-1:0]           w_wr_hit, w_rd_hit, w_wr_acc, w_rd_acc;
    logic                     w_wr_ok, w_rd_ok, w_wr_en, w_rd_en;
    logic [MW-1:0]            w_wr_addr, w_rd_addr;

    // Requests are judged on the registered (pre-edge) flags, so a same-channel
    // write/read pair on a full or empty channel resolves without any bypass path.
    always_comb begin
        w_wr_ok   = wr_en && (int'(wr_ch) < NCH);
        w_rd_ok   = rd_en && (int'(rd_ch) < NCH);
        w_wr_addr = '0;
        w_rd_addr = '0;
        for (int i = 0; i < NCH; i++) begin
            w_wr_hit[i]   = w_wr_ok && (wr_ch == CHW'(i));
            w_rd_hit[i]   = w_rd_ok && (rd_ch == CHW'(i));
            w_wr_acc[i]   = 1'b0;
            w_rd_acc[i]   = 1'b0;
            w_wptr_nxt[i] = r_wptr[i];
            w_rptr_nxt[i] = r_rptr[i];
            w_ovf_nxt[i]  = r_ovf[i];
            w_udf_nxt[i]  = r_udf[i];

            if (flush[i]) begin
                w_wptr_nxt[i] = '0;
                w_rptr_nxt[i] = '0;
                w_ovf_nxt[i]  = 1'b0;
                w_udf_nxt[i]  = 1'b0;
            end else begin
                if (w_wr_hit[i]) begin
                    if (r_full[i]) begin
                        w_ovf_nxt[i] = 1'b1;
                    end else begin
                        w_wr_acc[i]   = 1'b1;
                        w_wptr_nxt[i] = r_wptr[i] + PW'(1);
                    end
                end
                if (w_rd_hit[i]) begin
                    if (r_empty[i]) begin
                        w_udf_nxt[i] = 1'b1;
                    end else begin
                        w_rd_acc[i]   = 1'b1;
                        w_rptr_nxt[i] = r_rptr[i] + PW'(1);
                    end
                end
            end

            if (w_wr_hit[i]) w_wr_addr = {CHW'(i), r_wptr[i][AWIDTH-1:0]};
            if (w_rd_hit[i]) w_rd_addr = {CHW'(i), r_rptr[i][AWIDTH-1:0]};

            w_level_nxt[i] = w_wptr_nxt[i] - w_rptr_nxt[i];
            w_full_nxt[i]  = (w_level_nxt[i] == PW'(DEPTH));
            w_empty_nxt[i] = (w_level_nxt[i] == '0);
        end
        w_wr_en = |w_wr_acc;
        w_rd_en = |w_rd_acc;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_full     <= '0;
            r_empty    <= '1;
            r_ovf      <= '0;
            r_udf      <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_level    <= w_level_nxt;
            r_full     <= w_full_nxt;
            r_empty    <= w_empty_nxt;
            r_ovf      <= w_ovf_nxt;
            r_udf      <= w_udf_nxt;
            r_rd_valid <= w_rd_en;
            if (w_rd_en) r_rd_data <= r_mem[w_rd_addr];
        end
    end

    // NOTE: the storage array has no reset so it maps onto plain RAM; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[w_wr_addr] <= wr_data;
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign level    = r_level;
    assign ovf      = r_ovf;
    assign udf      = r_udf;
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;

endmodule
